// File: rtl/uart_msg_sender_if.sv
// Handshake bundle between the message sequencer and its uart_tx / uart_rx neighbours.
// master = sequencer side, slave = environment (trigger source, uart_tx, uart_rx).
interface uart_msg_sender_if #(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
);
  logic              mode;
  logic              trig;
  logic              chk_en;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_rdy;
  logic              active;
  logic              done;
  logic              overrun;
  logic              ack_err;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    input  mode, trig, chk_en, tx_busy, rx_data, rx_rdy,
    output tx_data, tx_start, active, done, overrun, ack_err, err_cnt
  );

  modport slave (
    output mode, trig, chk_en, tx_busy, rx_data, rx_rdy,
    input  tx_data, tx_start, active, done, overrun, ack_err, err_cnt
  );
endinterface

// File: rtl/uart_msg_sender.sv
// Streams a ROM-held message to uart_tx (periodic or triggered) and optionally checks
// the looped-back uart_rx stream against the same ROM, counting mismatches.
module uart_msg_sender #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int MSG_LEN = 16,
  parameter int PERIOD  = 12_000_000,
  parameter int ACK_TO  = 16,
  parameter int ERR_W   = 8,
  // ROM image, character 0 in the most significant byte so a string literal reads in order
  parameter logic [DEPTH*DATA_W-1:0] ROM_INIT = "Hello world!  \r\n"
) (
  input  logic                clk,
  input  logic                reset,
  uart_msg_sender_if.master   bus
);

  localparam int IDX_W = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
  localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int ACK_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    ACK,
    DRAIN
  } state_t;

  logic [DATA_W-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = ROM_INIT[(DEPTH-1-g)*DATA_W +: DATA_W];
  end

  state_t            state_q;
  logic              mode_q;
  logic [IDX_W-1:0]  tx_idx_q;
  logic [ACK_W-1:0]  ack_cnt_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic              active_q;
  logic              done_q;
  logic              overrun_q;
  logic              ack_err_q;
  logic [IDX_W-1:0]  rx_idx_q;
  logic [ERR_W-1:0]  err_cnt_q;

  logic wrap;
  logic req_mode;
  logic req;
  logic last_char;
  logic rx_mis;

  assign wrap      = (tmr_q == TMR_W'(PERIOD - 1));
  // Mode only takes effect in IDLE; in flight, requests are judged by the latched mode.
  assign req_mode  = (state_q == IDLE) ? bus.mode : mode_q;
  assign req       = req_mode ? bus.trig : wrap;
  assign last_char = (tx_idx_q == IDX_W'(MSG_LEN - 1));
  assign rx_mis    = (bus.rx_data != rom[rx_idx_q]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmr_q <= '0;
    else       tmr_q <= wrap ? '0 : tmr_q + TMR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      tx_idx_q   <= '0;
      ack_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      // The done cycle counts as busy: a request landing there is dropped, not queued.
      if (req && (state_q != IDLE || done_q)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          mode_q <= bus.mode;
          if (req && !done_q) begin
            tx_idx_q <= '0;
            active_q <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          tx_data_q <= rom[tx_idx_q];
          // Pulse together with the data when uart_tx is already free: 2-cycle latency.
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            ack_cnt_q  <= '0;
            state_q    <= ACK;
          end else begin
            state_q <= START;
          end
        end
        START: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            ack_cnt_q  <= '0;
            state_q    <= ACK;
          end
        end
        ACK: begin
          if (bus.tx_busy) begin
            state_q <= DRAIN;
          end else if (ack_cnt_q == ACK_W'(ACK_TO - 1)) begin
            ack_err_q <= 1'b1;
            active_q  <= 1'b0;
            state_q   <= IDLE;
          end else begin
            ack_cnt_q <= ack_cnt_q + ACK_W'(1);
          end
        end
        DRAIN: begin
          if (!bus.tx_busy) begin
            if (last_char) begin
              done_q   <= 1'b1;
              active_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              tx_idx_q <= tx_idx_q + IDX_W'(1);
              state_q  <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Loopback checker: its own index so rx lag behind tx is harmless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_idx_q  <= '0;
      err_cnt_q <= '0;
    end else if (!bus.chk_en) begin
      rx_idx_q <= '0;
    end else if (bus.rx_rdy) begin
      rx_idx_q <= (rx_idx_q == IDX_W'(MSG_LEN - 1)) ? '0 : rx_idx_q + IDX_W'(1);
      if (rx_mis && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.active   = active_q;
  assign bus.done     = done_q;
  assign bus.overrun  = overrun_q;
  assign bus.ack_err  = ack_err_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_msg_sender.sv
// Directed bench: instance a (16 chars, periodic) and instance b (5 chars, triggered),
// each driven by a small uart_tx/uart_rx loopback model.
module tb_uart_msg_sender;

  localparam int BUSY = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_msg_sender_if #(.DATA_W(8), .ERR_W(8)) bus_a ();
  uart_msg_sender_if #(.DATA_W(8), .ERR_W(8)) bus_b ();

  uart_msg_sender #(.MSG_LEN(16), .PERIOD(4000)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  uart_msg_sender #(.MSG_LEN(5),  .PERIOD(4000)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [16];

  int tests = 0;
  int fails = 0;

  logic [7:0] sent_a [$];
  logic [7:0] sent_b [$];
  int done_a = 0, done_b = 0, multi_a = 0, multi_b = 0;
  logic pst_a = 1'b0, pst_b = 1'b0;
  int cnt_a = 0, cnt_b = 0;
  logic [7:0] cur_b = '0;
  bit ack_en_b = 1'b1, force_bad = 1'b0, flip_req = 1'b0, flipped_b = 1'b0;

  // uart_tx model for a: busy rises the cycle after tx_start, holds BUSY cycles
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_a.tx_busy <= 1'b0;
      bus_a.rx_rdy  <= 1'b0;
      bus_a.rx_data <= '0;
      cnt_a         <= 0;
    end else if (bus_a.tx_start) begin
      bus_a.tx_busy <= 1'b1;
      cnt_a         <= BUSY;
    end else if (bus_a.tx_busy) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) bus_a.tx_busy <= 1'b0;
    end
  end

  // uart_tx + loopback uart_rx model for b, with optional corruption of the echoed byte
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_b.tx_busy <= 1'b0;
      bus_b.rx_rdy  <= 1'b0;
      bus_b.rx_data <= '0;
      cnt_b         <= 0;
    end else begin
      bus_b.rx_rdy <= 1'b0;
      if (bus_b.tx_start && ack_en_b) begin
        bus_b.tx_busy <= 1'b1;
        cnt_b         <= BUSY;
        cur_b         <= bus_b.tx_data;
      end else if (bus_b.tx_busy) begin
        cnt_b <= cnt_b - 1;
        if (cnt_b == 1) begin
          bus_b.tx_busy <= 1'b0;
          bus_b.rx_rdy  <= 1'b1;
          if (force_bad) bus_b.rx_data <= cur_b ^ 8'hFF;
          else if (flip_req && !flipped_b && cur_b == 8'h6F) begin
            bus_b.rx_data <= cur_b ^ 8'h01;
            flipped_b     <= 1'b1;
          end else bus_b.rx_data <= cur_b;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (bus_a.tx_start) sent_a.push_back(bus_a.tx_data);
    if (bus_b.tx_start) sent_b.push_back(bus_b.tx_data);
    if (bus_a.done) done_a <= done_a + 1;
    if (bus_b.done) done_b <= done_b + 1;
    if (bus_a.tx_start && pst_a) multi_a <= multi_a + 1;
    if (bus_b.tx_start && pst_b) multi_b <= multi_b + 1;
    pst_a <= bus_a.tx_start;
    pst_b <= bus_b.tx_start;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pulse_trig();
    @(negedge clk) bus_b.trig = 1'b1;
    @(negedge clk) bus_b.trig = 1'b0;
  endtask

  task automatic wait_done_b(input string nm, input int prev);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (done_b != prev) ok = 1'b1;
    end
    if (!ok) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_msg_b(input string nm);
    int prev;
    prev = done_b;
    pulse_trig();
    wait_done_b(nm, prev);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_hello(input string nm, input int base);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_chr%0d", nm, i), 32'(sent_b[base+i]), 32'(tbl[i].exp));
  endtask

  initial begin
    int base, prev;
    bit ok;

    tbl[0]  = '{0,  8'h48}; tbl[1]  = '{1,  8'h65}; tbl[2]  = '{2,  8'h6C}; tbl[3]  = '{3,  8'h6C};
    tbl[4]  = '{4,  8'h6F}; tbl[5]  = '{5,  8'h20}; tbl[6]  = '{6,  8'h77}; tbl[7]  = '{7,  8'h6F};
    tbl[8]  = '{8,  8'h72}; tbl[9]  = '{9,  8'h6C}; tbl[10] = '{10, 8'h64}; tbl[11] = '{11, 8'h21};
    tbl[12] = '{12, 8'h20}; tbl[13] = '{13, 8'h20}; tbl[14] = '{14, 8'h0D}; tbl[15] = '{15, 8'h0A};

    bus_a.mode = 1'b0; bus_a.trig = 1'b0; bus_a.chk_en = 1'b0;
    bus_b.mode = 1'b1; bus_b.trig = 1'b0; bus_b.chk_en = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_active",   32'(bus_b.active),   32'd0);
    check("rst_tx_start", 32'(bus_b.tx_start), 32'd0);
    check("rst_tx_data",  32'(bus_b.tx_data),  32'd0);
    check("rst_flags",    32'({bus_b.done, bus_b.overrun, bus_b.ack_err}), 32'd0);
    check("rst_err_cnt",  32'(bus_b.err_cnt),  32'd0);
    reset = 1'b0;

    // T1: periodic mode, nothing before the first timer wrap
    repeat (3900) @(negedge clk);
    check("T1_no_early_send", 32'(sent_a.size()), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (done_a >= 1) ok = 1'b1;
    end
    check("T1_first_done", 32'(ok), 32'd1);
    check("T1_count1", 32'(sent_a.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("T1a_chr%0d", tbl[i].idx), 32'(sent_a[i]), 32'(tbl[i].exp));
    check("T1_active_low", 32'(bus_a.active), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 4500 && !ok; i++) begin
      @(negedge clk);
      if (done_a >= 2) ok = 1'b1;
    end
    check("T1_second_done", 32'(ok), 32'd1);
    check("T1_count2", 32'(sent_a.size()), 32'd32);
    for (int i = 0; i < 16; i++)
      check($sformatf("T1b_chr%0d", tbl[i].idx), 32'(sent_a[16+i]), 32'(tbl[i].exp));
    check("T1_one_cycle_start", 32'(multi_a), 32'd0);

    // T2: triggered "Hello", 2-cycle request-to-start latency
    base = sent_b.size(); prev = done_b;
    check("T2_idle_no_send", 32'(base), 32'd0);
    @(negedge clk) bus_b.trig = 1'b1;
    @(negedge clk) bus_b.trig = 1'b0;
    check("T2_active_load", 32'(bus_b.active),   32'd1);
    check("T2_start_not_yet", 32'(bus_b.tx_start), 32'd0);
    @(negedge clk);
    check("T2_start_lat2", 32'(bus_b.tx_start), 32'd1);
    check("T2_first_data", 32'(bus_b.tx_data),  32'h48);
    wait_done_b("T2", prev);
    check("T2_count", 32'(sent_b.size() - base), 32'd5);
    check_hello("T2", base);
    check("T2_done_once", 32'(done_b - prev), 32'd1);
    check("T2_active_low", 32'(bus_b.active), 32'd0);
    check("T2_overrun_clr", 32'(bus_b.overrun), 32'd0);
    repeat (200) @(negedge clk);
    check("T2_no_send_wo_trig", 32'(sent_b.size() - base), 32'd5);

    // T3: second trigger mid-message flags overrun and is not queued
    base = sent_b.size(); prev = done_b;
    pulse_trig();
    repeat (20) @(negedge clk);
    check("T3_mid_active", 32'(bus_b.active), 32'd1);
    pulse_trig();
    wait_done_b("T3", prev);
    check("T3_overrun", 32'(bus_b.overrun), 32'd1);
    check_hello("T3", base);
    repeat (200) @(negedge clk);
    check("T3_not_queued", 32'(sent_b.size() - base), 32'd5);
    check("T3_done_once", 32'(done_b - prev), 32'd1);

    // T5: loopback checker
    @(negedge clk) bus_b.chk_en = 1'b1;
    for (int m = 0; m < 3; m++) run_msg_b("T5_clean");
    check("T5_err_zero", 32'(bus_b.err_cnt), 32'd0);
    flip_req = 1'b1;
    run_msg_b("T5_flip");
    check("T5_err_one", 32'(bus_b.err_cnt), 32'd1);
    force_bad = 1'b1;
    for (int m = 0; m < 50; m++) run_msg_b("T5_bad");
    check("T5_err_251", 32'(bus_b.err_cnt), 32'd251);
    for (int m = 0; m < 10; m++) run_msg_b("T5_sat");
    check("T5_err_sat", 32'(bus_b.err_cnt), 32'd255);
    force_bad = 1'b0;
    @(negedge clk) bus_b.chk_en = 1'b0;

    // T4: uart_tx never acknowledges -> ack_err exactly 16 cycles after tx_start
    ack_en_b = 1'b0; prev = done_b;
    check("T4_ack_err_clr", 32'(bus_b.ack_err), 32'd0);
    pulse_trig();
    @(negedge clk);
    check("T4_start", 32'(bus_b.tx_start), 32'd1);
    repeat (15) @(negedge clk);
    check("T4_ack_err_early", 32'(bus_b.ack_err), 32'd0);
    check("T4_active_wait",   32'(bus_b.active),  32'd1);
    @(negedge clk);
    check("T4_ack_err", 32'(bus_b.ack_err), 32'd1);
    check("T4_aborted", 32'(bus_b.active),  32'd0);
    repeat (20) @(negedge clk);
    check("T4_no_done", 32'(done_b - prev), 32'd0);
    ack_en_b = 1'b1;

    // T6: async reset while char 3 is being started
    base = sent_b.size(); prev = done_b;
    pulse_trig();
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus_b.tx_start && sent_b.size() == base + 3) ok = 1'b1;
      else @(negedge clk);
    end
    check("T6_reached_chr3", 32'(ok), 32'd1);
    reset = 1'b1;
    #1;
    check("T6_rst_tx_start", 32'(bus_b.tx_start), 32'd0);
    check("T6_rst_active",   32'(bus_b.active),   32'd0);
    check("T6_rst_tx_data",  32'(bus_b.tx_data),  32'd0);
    check("T6_rst_sticky",   32'({bus_b.overrun, bus_b.ack_err}), 32'd0);
    check("T6_rst_err_cnt",  32'(bus_b.err_cnt),  32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("T6_no_done", 32'(done_b - prev), 32'd0);
    check("T6_no_more_send", 32'(sent_b.size() - base), 32'd3);
    base = sent_b.size(); prev = done_b;
    pulse_trig();
    wait_done_b("T6_resend", prev);
    check("T6_resend_count", 32'(sent_b.size() - base), 32'd5);
    check_hello("T6", base);
    check("T6_one_cycle_start", 32'(multi_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
